// File: rtl/coin_dispense_sequencer_pkg.sv
// Shared types and constants for the coin dispense sequencer: FSM states,
// channel indices and the payout priority order.
package coin_dispense_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        PUSH,
        WAIT_BEAM,
        SETTLE,
        ERROR
    } state_t;

    localparam int N_CH = 4;

    localparam logic [1:0] CH_1  = 2'd0;
    localparam logic [1:0] CH_5  = 2'd1;
    localparam logic [1:0] CH_10 = 2'd2;
    localparam logic [1:0] CH_25 = 2'd3;

    // Packed lowest-priority first, so a forward scan leaves the highest winner.
    localparam logic [7:0] PRIO_ORDER = {CH_25, CH_10, CH_5, CH_1};

    // Returns {found, channel} for the highest-priority channel with coins left.
    function automatic logic [2:0] pick_channel(input logic [N_CH-1:0] nonzero);
        logic [2:0] sel;
        logic [1:0] ch;
        sel = 3'b000;
        for (int i = 0; i < N_CH; i++) begin
            ch = PRIO_ORDER[2*i +: 2];
            if (nonzero[ch]) sel = {1'b1, ch};
        end
        return sel;
    endfunction

endpackage

// File: rtl/coin_dispense_sequencer_if.sv
// CPU-side request/status bundle of the coin dispense sequencer.
interface coin_dispense_sequencer_if #(
    parameter int CNT_W = 8
);
    logic               start;
    logic               abort;
    logic [CNT_W-1:0]   count_1;
    logic [CNT_W-1:0]   count_5;
    logic [CNT_W-1:0]   count_10;
    logic [CNT_W-1:0]   count_25;
    logic               busy;
    logic               done;
    logic               error;
    logic [4*CNT_W-1:0] remaining;

    modport master (
        output start, abort, count_1, count_5, count_10, count_25,
        input  busy, done, error, remaining
    );

    modport slave (
        input  start, abort, count_1, count_5, count_10, count_25,
        output busy, done, error, remaining
    );
endinterface

// File: rtl/coin_dispense_sequencer_beam_edge_sync.sv
// Two-flop synchronizer for one asynchronous beam-break input, followed by
// a rising-edge detector producing a single-cycle pulse.
module beam_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);
    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= raw;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign pulse = sync & ~sync_d;
endmodule

// File: rtl/coin_dispense_sequencer.sv
// Fires the coin-ejector servos one coin at a time, largest denomination
// first, confirming each coin by its beam break and retrying on timeout.
module coin_dispense_sequencer
    import coin_dispense_pkg::*;
#(
    parameter int PUSH_CYCLES    = 15000000,
    parameter int TIMEOUT_CYCLES = 30000000,
    parameter int SETTLE_CYCLES  = 6000000,
    parameter int MAX_RETRY      = 2,
    parameter int CNT_W          = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    coin_dispense_sequencer_if.slave bus,
    input  logic [N_CH-1:0]         beam_raw,
    output logic [N_CH-1:0]         servo_ctrl
);
    localparam int TMAX_A    = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int TIMER_MAX = (TMAX_A > PUSH_CYCLES) ? TMAX_A : PUSH_CYCLES;
    localparam int TW        = $clog2(TIMER_MAX + 1);
    localparam int RW        = $clog2(MAX_RETRY + 2);
    localparam int RMW       = N_CH * CNT_W;

    state_t           state, state_n;
    logic [1:0]       ch, ch_n;
    logic [RW-1:0]    retry, retry_n;
    logic [TW-1:0]    timer, timer_n, timer_inc;
    logic [RMW-1:0]   rem, rem_n;
    logic [CNT_W-1:0] rem_ch;
    logic [N_CH-1:0]  beam_edge, nonzero, servo_n;
    logic [2:0]       pick;
    logic             busy_q, done_q, error_q, done_n;

    for (genvar g = 0; g < N_CH; g++) begin : g_beam
        beam_edge_sync u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (beam_raw[g]),
            .pulse (beam_edge[g])
        );
        assign nonzero[g] = |rem[g*CNT_W +: CNT_W];
    end

    always_comb begin
        state_n   = state;
        ch_n      = ch;
        retry_n   = retry;
        timer_n   = timer;
        rem_n     = rem;
        done_n    = 1'b0;
        pick      = pick_channel(nonzero);
        rem_ch    = rem[int'(ch)*CNT_W +: CNT_W];
        timer_inc = (timer == TW'(TIMER_MAX)) ? timer : timer + 1'b1;

        case (state)
            IDLE, ERROR: begin
                if (bus.start) begin
                    rem_n   = {bus.count_25, bus.count_10, bus.count_5, bus.count_1};
                    retry_n = '0;
                    state_n = SELECT;
                end
            end
            SELECT: begin
                if (pick[2]) begin
                    ch_n    = pick[1:0];
                    timer_n = '0;
                    state_n = PUSH;
                end else begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            PUSH, WAIT_BEAM: begin
                timer_n = timer_inc;
                // The retry count is per coin: a confirmed coin resets it.
                if (beam_edge[ch]) begin
                    if (rem_ch != '0) rem_n[int'(ch)*CNT_W +: CNT_W] = rem_ch - 1'b1;
                    retry_n = '0;
                    timer_n = '0;
                    state_n = SETTLE;
                end else if (timer >= TW'(TIMEOUT_CYCLES - 1)) begin
                    timer_n = '0;
                    if (retry < RW'(MAX_RETRY)) begin
                        retry_n = retry + 1'b1;
                        state_n = SETTLE;
                    end else begin
                        state_n = ERROR;
                    end
                end else if (state == PUSH && timer >= TW'(PUSH_CYCLES - 1)) begin
                    state_n = WAIT_BEAM;
                end
            end
            SETTLE: begin
                timer_n = timer_inc;
                if (timer >= TW'(SETTLE_CYCLES - 1)) begin
                    timer_n = '0;
                    state_n = SELECT;
                end
            end
            default: state_n = IDLE;
        endcase

        if (bus.abort) begin
            state_n = IDLE;
            rem_n   = '0;
            retry_n = '0;
            timer_n = '0;
            done_n  = 1'b0;
        end

        servo_n = (state_n == PUSH) ? (N_CH'(1) << ch_n) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ch         <= CH_1;
            retry      <= '0;
            timer      <= '0;
            rem        <= '0;
            servo_ctrl <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state      <= state_n;
            ch         <= ch_n;
            retry      <= retry_n;
            timer      <= timer_n;
            rem        <= rem_n;
            servo_ctrl <= servo_n;
            busy_q     <= (state_n inside {SELECT, PUSH, WAIT_BEAM, SETTLE});
            done_q     <= done_n;
            error_q    <= (state_n == ERROR);
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.remaining = rem;
endmodule

// File: tb/tb_coin_dispense_sequencer.sv
// Directed and randomized bench for coin_dispense_sequencer with short timer
// parameters and a coin-level reference model (expected order and counts).
module tb_coin_dispense_sequencer;
    localparam int CNT_W  = 8;
    localparam int PUSH   = 40;
    localparam int TMO    = 100;
    localparam int SETTLE = 12;
    localparam int MAXR   = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] beam_raw = 4'b0000;
    logic [3:0] servo_ctrl;

    coin_dispense_sequencer_if #(.CNT_W(CNT_W)) bus();

    coin_dispense_sequencer #(
        .PUSH_CYCLES    (PUSH),
        .TIMEOUT_CYCLES (TMO),
        .SETTLE_CYCLES  (SETTLE),
        .MAX_RETRY      (MAXR),
        .CNT_W          (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .beam_raw   (beam_raw),
        .servo_ctrl (servo_ctrl)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int exp_rem[4];
    int order[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] pack_rem();
        return {exp_rem[3][7:0], exp_rem[2][7:0], exp_rem[1][7:0], exp_rem[0][7:0]};
    endfunction

    function automatic logic [3:0] onehot(input int c);
        return 4'(1 << c);
    endfunction

    // Expected servo order: largest denomination first, one entry per coin.
    task automatic build_order();
        order.delete();
        for (int c = 3; c >= 0; c--)
            for (int k = 0; k < exp_rem[c]; k++) order.push_back(c);
    endtask

    task automatic do_start(input int c1, input int c5, input int c10, input int c25);
        bus.count_1  = 8'(c1);
        bus.count_5  = 8'(c5);
        bus.count_10 = 8'(c10);
        bus.count_25 = 8'(c25);
        bus.start    = 1'b1;
        exp_rem[0] = c1; exp_rem[1] = c5; exp_rem[2] = c10; exp_rem[3] = c25;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_servo(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (servo_ctrl != 4'b0000) break;
            @(negedge clk);
        end
        check("servo_rise_in_time", 64'(servo_ctrl != 4'b0000), 64'd1);
    endtask

    task automatic feed_coin(input int c, input int d, input bit glitch);
        int other;
        repeat (d) @(negedge clk);
        if (glitch) begin
            other = (c + 2) % 4;
            beam_raw[other] = 1'b1;
            bus.count_1 = 8'd9; bus.count_5 = 8'd9; bus.count_10 = 8'd9; bus.count_25 = 8'd9;
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            beam_raw[other] = 1'b0;
            repeat (3) @(negedge clk);
            check("glitch_no_change", bus.remaining, pack_rem());
            check("start_busy_ignored", servo_ctrl, onehot(c));
        end
        beam_raw[c] = 1'b1;
        repeat (2) @(negedge clk);
        check("rem_before_sync", bus.remaining, pack_rem());
        @(negedge clk);
        if (exp_rem[c] > 0) exp_rem[c]--;
        check("rem_decrement", bus.remaining, pack_rem());
        check("servo_drop", servo_ctrl, 4'b0000);
        beam_raw[c] = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bus.done) break;
        end
        check("done_pulse", bus.done, 1'b1);
        check("busy_fall_with_done", bus.busy, 1'b0);
        check("error_clear", bus.error, 1'b0);
        check("rem_at_done", bus.remaining, pack_rem());
        @(negedge clk);
        check("done_one_cycle", bus.done, 1'b0);
    endtask

    task automatic run_payout(input int c1, input int c5, input int c10, input int c25, input bit glitch);
        do_start(c1, c5, c10, c25);
        build_order();
        check("busy_rise", bus.busy, 1'b1);
        check("servo_early", servo_ctrl, 4'b0000);
        check("error_cleared_on_start", bus.error, 1'b0);
        @(negedge clk);
        if (order.size() == 0) begin
            check("zero_done", bus.done, 1'b1);
            check("zero_busy", bus.busy, 1'b0);
            check("zero_servo", servo_ctrl, 4'b0000);
            @(negedge clk);
            check("zero_done_one_cycle", bus.done, 1'b0);
            return;
        end
        check("servo_first", servo_ctrl, onehot(order[0]));
        for (int k = 0; k < order.size(); k++) begin
            wait_servo(200);
            check("servo_order", servo_ctrl, onehot(order[k]));
            feed_coin(order[k], $urandom_range(1, 60), glitch && (k == 0));
        end
        wait_done(100);
    endtask

    initial begin
        int rises;
        int done_seen;
        int c;
        bit seen_off;
        logic [3:0] prev;

        bus.start = 1'b0; bus.abort = 1'b0;
        bus.count_1 = '0; bus.count_5 = '0; bus.count_10 = '0; bus.count_25 = '0;
        for (int i = 0; i < 4; i++) exp_rem[i] = 0;
        repeat (3) @(negedge clk);
        check("rst_servo", servo_ctrl, 4'b0000);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_error", bus.error, 1'b0);
        check("rst_remaining", bus.remaining, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed mix: 25 once, 5 once, 1 twice.
        run_payout(2, 1, 0, 1, 1'b0);
        // Off-channel glitch plus start while busy.
        run_payout(0, 1, 0, 1, 1'b1);
        run_payout(0, 0, 0, 0, 1'b0);
        for (int r = 0; r < 3; r++)
            run_payout($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                       $urandom_range(0, 2), 1'b0);

        // No beam ever: three attempts then error.
        do_start(1, 0, 0, 0);
        rises = 0; done_seen = 0; prev = 4'b0000;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (prev == 4'b0000 && servo_ctrl != 4'b0000) rises++;
            if (bus.done) done_seen++;
            prev = servo_ctrl;
            if (bus.error) break;
        end
        check("retry_attempts", rises, 3);
        check("retry_error", bus.error, 1'b1);
        check("retry_busy", bus.busy, 1'b0);
        check("retry_servo", servo_ctrl, 4'b0000);
        check("retry_remaining", bus.remaining, pack_rem());
        check("retry_no_done", done_seen, 0);
        repeat (20) @(negedge clk);
        check("error_sticky", bus.error, 1'b1);
        run_payout(0, 1, 0, 0, 1'b0);

        // Timeout on the first attempt, beam on the retry.
        c = $urandom_range(0, 3);
        do_start(c == 0, c == 1, c == 2, c == 3);
        @(negedge clk);
        check("tmo_first_servo", servo_ctrl, onehot(c));
        seen_off = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (servo_ctrl == 4'b0000) seen_off = 1'b1;
            if (seen_off && servo_ctrl != 4'b0000) break;
        end
        check("tmo_retry_servo", servo_ctrl, onehot(c));
        check("tmo_rem_kept", bus.remaining, pack_rem());
        feed_coin(c, $urandom_range(1, 60), 1'b0);
        wait_done(100);

        // Abort mid-push, then abort beating start in the same cycle.
        do_start(0, 0, 3, 0);
        @(negedge clk);
        check("abort_servo_on", servo_ctrl, onehot(2));
        repeat (5) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        for (int i = 0; i < 4; i++) exp_rem[i] = 0;
        check("abort_servo", servo_ctrl, 4'b0000);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_remaining", bus.remaining, 32'd0);
        bus.count_25 = 8'd1; bus.abort = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0; bus.start = 1'b0;
        check("abort_over_start", bus.busy, 1'b0);
        run_payout($urandom_range(0, 2), 1, $urandom_range(0, 2), 0, 1'b0);

        // Asynchronous reset in the middle of a push.
        do_start(0, 0, 0, 2);
        repeat (4) @(negedge clk);
        check("pre_reset_servo", servo_ctrl, onehot(3));
        #2 rst_n = 1'b0;
        #1;
        check("areset_servo", servo_ctrl, 4'b0000);
        check("areset_busy", bus.busy, 1'b0);
        check("areset_done", bus.done, 1'b0);
        check("areset_error", bus.error, 1'b0);
        check("areset_remaining", bus.remaining, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_busy", bus.busy, 1'b0);
        check("post_reset_servo", servo_ctrl, 4'b0000);
        run_payout(0, 0, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
